// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with shift-enable pacing, seamless back-to-back
// reload and busy/done/overrun status flags.
module piso_serializer #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt, overrun_nxt;

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          sreg_nxt  = din;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (en && cnt == LAST) begin
          // Last bit consumed: a simultaneous start reloads with no gap bit.
          done_nxt = 1'b1;
          if (start) begin
            sreg_nxt = din;
            cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
          end
        end else begin
          if (en) begin
            sreg_nxt = shift_word(sreg);
            cnt_nxt  = cnt + 1'b1;
          end
          overrun_nxt = start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output flops are loaded from next-state values so dout/busy track state with no extra latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      dout       <= (state_nxt == SHIFT) ? out_bit(sreg_nxt) : 1'b0;
      dout_valid <= (state_nxt == SHIFT);
      busy       <= (state_nxt == SHIFT);
      done       <= done_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a 16-bit MSB-first and an 8-bit LSB-first instance,
// directed scenarios plus random traffic against a word/index reference model.
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st0, en0, st1, en1;
  logic [15:0] d0;
  logic [7:0]  d1;
  logic        o0_dout, o0_vld, o0_busy, o0_done, o0_ovr;
  logic        o1_dout, o1_vld, o1_busy, o1_done, o1_ovr;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .start(st0), .din(d0), .en(en0),
    .dout(o0_dout), .dout_valid(o0_vld), .busy(o0_busy), .done(o0_done), .overrun(o0_ovr)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start(st1), .din(d1), .en(en1),
    .dout(o1_dout), .dout_valid(o1_vld), .busy(o1_busy), .done(o1_done), .overrun(o1_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the word in flight and how many of its bits have been consumed.
  typedef struct {
    bit          act;
    logic [31:0] word;
    int          idx;
    bit          done;
    bit          ovr;
  } mst_t;

  mst_t m0, m1;

  function automatic mst_t step(input mst_t s, input int w, input logic r, input logic st,
                                input logic [31:0] d, input logic e);
    mst_t n;
    n = s;
    n.done = 1'b0;
    n.ovr  = 1'b0;
    if (r) begin
      n.act = 1'b0; n.idx = 0; n.word = '0;
    end else if (!s.act) begin
      if (st) begin n.act = 1'b1; n.word = d; n.idx = 0; end
    end else if (e && s.idx == w - 1) begin
      n.done = 1'b1;
      if (st) begin n.word = d; n.idx = 0; end
      else n.act = 1'b0;
    end else begin
      if (e) n.idx = s.idx + 1;
      if (st) n.ovr = 1'b1;
    end
    return n;
  endfunction

  function automatic logic exp_dout(input mst_t s, input int w, input bit lsb);
    if (!s.act) return 1'b0;
    return lsb ? s.word[s.idx] : s.word[w - 1 - s.idx];
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, 16, rst, st0, {16'b0, d0}, en0);
    m1 <= step(m1, 8, rst, st1, {24'b0, d1}, en1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("msb_dout",    o0_dout, exp_dout(m0, 16, 1'b0));
      chk("msb_valid",   o0_vld,  m0.act);
      chk("msb_busy",    o0_busy, m0.act);
      chk("msb_done",    o0_done, m0.done);
      chk("msb_overrun", o0_ovr,  m0.ovr);
      chk("lsb_dout",    o1_dout, exp_dout(m1, 8, 1'b1));
      chk("lsb_valid",   o1_vld,  m1.act);
      chk("lsb_busy",    o1_busy, m1.act);
      chk("lsb_done",    o1_done, m1.done);
      chk("lsb_overrun", o1_ovr,  m1.ovr);
    end
  end

  logic [15:0] cap16;
  logic [7:0]  cap8;
  logic [31:0] cap32;
  logic [15:0] w;
  int          ndone, nbusy, novr;

  initial begin
    rst = 1'b1; st0 = 1'b1; st1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
    d0 = 16'hBEEF; d1 = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {o0_dout, o0_vld, o0_busy, o0_done, o0_ovr,
                        o1_dout, o1_vld, o1_busy, o1_done, o1_ovr}, 32'h0);
    chk_on = 1'b1;
    rst = 1'b0; st0 = 1'b0; st1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {o0_busy, o1_busy}, 32'h0);

    // MSB 16'hA5C3, en held high
    st0 = 1'b1; d0 = 16'hA5C3; en0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0; d0 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      cap16[15 - i] = o0_dout;
      @(negedge clk);
    end
    chk("msb_word", cap16, 32'hA5C3);
    chk("msb_done_c17", o0_done, 32'h1);
    chk("msb_idle_c17", o0_vld, 32'h0);

    // LSB 8'h96 with en toggling
    st1 = 1'b1; d1 = 8'h96; en1 = 1'b0;
    @(negedge clk);
    st1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 0) cap8[j / 2] = o1_dout;
      en1 = (j % 2 == 1);
      @(negedge clk);
    end
    chk("lsb_word", cap8, 32'h96);
    chk("lsb_done", o1_done, 32'h1);
    en1 = 1'b1;

    // back-to-back FFFF then 0000 on the last-bit edge
    st0 = 1'b1; d0 = 16'hFFFF; en0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 32; i++) begin
      cap32[31 - i] = o0_dout;
      nbusy += int'(o0_busy);
      ndone += int'(o0_done);
      if (i == 15) begin st0 = 1'b1; d0 = 16'h0000; end
      else st0 = 1'b0;
      @(negedge clk);
    end
    ndone += int'(o0_done);
    chk("b2b_bits", cap32, 32'hFFFF0000);
    chk("b2b_busy", nbusy, 32);
    chk("b2b_done", ndone, 2);

    // overrun at bit 5
    w = 16'($urandom);
    st0 = 1'b1; d0 = w;
    @(negedge clk);
    st0 = 1'b0;
    novr = 0;
    for (int i = 0; i < 16; i++) begin
      cap16[15 - i] = o0_dout;
      novr += int'(o0_ovr);
      if (i == 5) begin st0 = 1'b1; d0 = ~w; end
      else st0 = 1'b0;
      @(negedge clk);
    end
    chk("ovr_word", cap16, {16'b0, w});
    chk("ovr_count", novr, 1);
    chk("ovr_done", o0_done, 32'h1);

    // reset mid-word at bit 9
    st0 = 1'b1; d0 = 16'h5555;
    @(negedge clk);
    st0 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", {o0_dout, o0_vld, o0_busy, o0_done, o0_ovr}, 32'h0);
    @(negedge clk);
    chk("midrst_no_done", o0_done, 32'h0);

    // random traffic, occasional reset
    for (int c = 0; c < 4000; c++) begin
      st0 = ($urandom_range(0, 7) == 0);
      st1 = ($urandom_range(0, 5) == 0);
      d0  = 16'($urandom);
      d1  = 8'($urandom);
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
